// File: rtl/p4_output_merger.sv
// Merges SDNet packet beats with their per-packet tuple, drops flagged packets,
// and forwards survivors through one output register with the tuple on TUSER.
module p4_output_merger #(
  parameter int TUPLE_DEPTH = 4,
  parameter int DROP_BIT    = 127,
  parameter int CNT_W       = 32
) (
  input  logic              clk_line,
  input  logic              clk_line_rst,
  input  logic              packet_out_packet_out_TVALID,
  output logic              packet_out_packet_out_TREADY,
  input  logic [255:0]      packet_out_packet_out_TDATA,
  input  logic [31:0]       packet_out_packet_out_TKEEP,
  input  logic              packet_out_packet_out_TLAST,
  input  logic              tuple_out_tuple_out_VALID,
  input  logic [127:0]      tuple_out_tuple_out_DATA,
  output logic              m_axis_TVALID,
  input  logic              m_axis_TREADY,
  output logic [255:0]      m_axis_TDATA,
  output logic [31:0]       m_axis_TKEEP,
  output logic              m_axis_TLAST,
  output logic [127:0]      m_axis_TUSER,
  output logic [CNT_W-1:0]  stat_fwd_pkts,
  output logic [CNT_W-1:0]  stat_drop_pkts,
  output logic              tuple_overflow
);
  localparam int AW = $clog2(TUPLE_DEPTH);

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [127:0] user;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  logic [127:0] mem [TUPLE_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, push, pop;
  logic [127:0] head, cur_tuple, load_user;
  state_t       state, state_nxt;
  logic         tready, load, drop_last, slot_free;
  beat_t        out_q;

  // Extra MSB on the pointers separates full from empty when the low bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign push      = tuple_out_tuple_out_VALID && (!full || pop);
  assign slot_free = !m_axis_TVALID || m_axis_TREADY;

  always_comb begin
    state_nxt = state;
    tready    = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    drop_last = 1'b0;
    load_user = cur_tuple;
    case (state)
      IDLE: begin
        tready = !empty && (head[DROP_BIT] || slot_free);
        if (packet_out_packet_out_TVALID && tready) begin
          pop = 1'b1;
          if (head[DROP_BIT]) begin
            if (packet_out_packet_out_TLAST) drop_last = 1'b1;
            else                             state_nxt = DROP;
          end else begin
            load      = 1'b1;
            load_user = head;
            if (!packet_out_packet_out_TLAST) state_nxt = FWD;
          end
        end
      end
      FWD: begin
        tready = slot_free;
        if (packet_out_packet_out_TVALID && tready) begin
          load = 1'b1;
          if (packet_out_packet_out_TLAST) state_nxt = IDLE;
        end
      end
      DROP: begin
        tready = 1'b1;
        if (packet_out_packet_out_TVALID && packet_out_packet_out_TLAST) begin
          drop_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign packet_out_packet_out_TREADY = tready;

  always_ff @(posedge clk_line) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tuple_out_tuple_out_DATA;
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      state          <= IDLE;
      cur_tuple      <= '0;
      tuple_overflow <= 1'b0;
      stat_fwd_pkts  <= '0;
      stat_drop_pkts <= '0;
      out_q          <= '0;
      m_axis_TVALID  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        cur_tuple <= head;
      end
      if (tuple_out_tuple_out_VALID && full && !pop) tuple_overflow <= 1'b1;
      if (drop_last) stat_drop_pkts <= stat_drop_pkts + CNT_W'(1);
      if (m_axis_TVALID && m_axis_TREADY && m_axis_TLAST)
        stat_fwd_pkts <= stat_fwd_pkts + CNT_W'(1);
      // Output register: load wins, otherwise drain to zero once consumed.
      if (load) begin
        out_q         <= '{data: packet_out_packet_out_TDATA, keep: packet_out_packet_out_TKEEP,
                           last: packet_out_packet_out_TLAST, user: load_user};
        m_axis_TVALID <= 1'b1;
      end else if (m_axis_TREADY) begin
        out_q         <= '0;
        m_axis_TVALID <= 1'b0;
      end
    end
  end

  assign m_axis_TDATA = out_q.data;
  assign m_axis_TKEEP = out_q.keep;
  assign m_axis_TLAST = out_q.last;
  assign m_axis_TUSER = out_q.user;
endmodule

// File: tb/tb_p4_output_merger.sv
// Bench for p4_output_merger: queue-based packet/tuple model checked every cycle
// on the falling edge, plus directed scenarios with literal expectations.
module tb_p4_output_merger;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pk_valid = 1'b0, pk_last = 1'b0, tready;
  logic [255:0] pk_data = '0;
  logic [31:0]  pk_keep = '0;
  logic         tv = 1'b0;
  logic [127:0] td = '0;
  logic         m_valid, m_ready = 1'b1, m_last;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic [127:0] m_user;
  logic [31:0]  fwd_cnt, drop_cnt;
  logic         ovf;

  int n_cmp = 0, n_bad = 0;

  p4_output_merger #(.TUPLE_DEPTH(4), .DROP_BIT(127), .CNT_W(32)) dut (
    .clk_line(clk), .clk_line_rst(rst),
    .packet_out_packet_out_TVALID(pk_valid), .packet_out_packet_out_TREADY(tready),
    .packet_out_packet_out_TDATA(pk_data), .packet_out_packet_out_TKEEP(pk_keep),
    .packet_out_packet_out_TLAST(pk_last),
    .tuple_out_tuple_out_VALID(tv), .tuple_out_tuple_out_DATA(td),
    .m_axis_TVALID(m_valid), .m_axis_TREADY(m_ready), .m_axis_TDATA(m_data),
    .m_axis_TKEEP(m_keep), .m_axis_TLAST(m_last), .m_axis_TUSER(m_user),
    .stat_fwd_pkts(fwd_cnt), .stat_drop_pkts(drop_cnt), .tuple_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: a tuple queue of capacity 4 and a queue of beats owed to the sink.
  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [127:0] u;
  } mbeat_t;

  mbeat_t       eq[$];
  logic [127:0] tq[$];
  mbeat_t       mb;
  logic [127:0] cur;
  logic         in_pkt = 1'b0, pkt_drop = 1'b0, m_ovf = 1'b0, sf, etr;
  logic [31:0]  m_fwd = '0, m_drop = '0;

  always @(negedge clk) begin
    sf  = (eq.size() == 0) || m_ready;
    etr = in_pkt ? (pkt_drop ? 1'b1 : sf) : (tq.size() > 0 && (tq[0][127] || sf));
    chk("m_tvalid", m_valid, eq.size() != 0);
    if (eq.size() != 0) begin
      chk("m_tdata", m_data, eq[0].d);
      chk("m_tkeep", m_keep, eq[0].k);
      chk("m_tlast", m_last, eq[0].l);
      chk("m_tuser", m_user, eq[0].u);
    end
    chk("in_tready", tready, etr);
    chk("stat_fwd", fwd_cnt, m_fwd);
    chk("stat_drop", drop_cnt, m_drop);
    chk("overflow", ovf, m_ovf);
    if (rst) begin
      eq.delete(); tq.delete();
      in_pkt = 1'b0; pkt_drop = 1'b0; m_ovf = 1'b0; m_fwd = '0; m_drop = '0;
    end else begin
      if (eq.size() != 0 && m_ready) begin
        mb = eq.pop_front();
        if (mb.l) m_fwd++;
      end
      if (pk_valid && etr) begin
        if (!in_pkt) begin
          cur = tq.pop_front();
          pkt_drop = cur[127];
          in_pkt = 1'b1;
        end
        if (pkt_drop) begin
          if (pk_last) m_drop++;
        end else eq.push_back({pk_data, pk_keep, pk_last, cur});
        if (pk_last) in_pkt = 1'b0;
      end
      // Pop above happens first, so a full queue still accepts a same-cycle tuple.
      if (tv) begin
        if (tq.size() < 4) tq.push_back(td);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_tuple(input logic [127:0] t);
    tv = 1'b1; td = t; tick(); tv = 1'b0;
  endtask

  int first_wait;

  task automatic send_pkt(input int n, input logic [7:0] tag, input logic tup_en,
                          input logic [127:0] tup);
    logic acc;
    for (int b = 0; b < n; b++) begin
      pk_valid = 1'b1;
      pk_data  = {32{tag ^ 8'(b)}};
      pk_keep  = {tag, 8'(b), 16'hF0F0};
      pk_last  = (b == n - 1);
      if (b == 0 && tup_en) begin tv = 1'b1; td = tup; end
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk); acc = tready;
        if (b == 0 && !acc) first_wait++;
        @(posedge clk); #1; tv = 1'b0;
      end
      if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    end
    pk_valid = 1'b0; pk_last = 1'b0;
  endtask

  task automatic settle_and_check(input string nm, input int f, input int d, input logic o);
    repeat (3) tick();
    @(negedge clk);
    chk({nm, "_fwd"}, fwd_cnt, 32'(f));
    chk({nm, "_drop"}, drop_cnt, 32'(d));
    chk({nm, "_ovf"}, ovf, o);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", m_valid, 1'b0);
    chk("rst_tready", tready, 1'b0);
    chk("rst_fwd", fwd_cnt, 32'd0);
    tick();

    // 1: forward 3-beat packet, first output the cycle after acceptance
    send_tuple(128'h1);
    pk_valid = 1'b1; pk_data = {32{8'hA0}}; pk_keep = 32'hFFFF_FFFF; pk_last = 1'b0;
    tick();
    @(negedge clk);
    chk("t1_b0_tvalid", m_valid, 1'b1);
    chk("t1_b0_tuser", m_user, 128'h1);
    chk("t1_b0_tdata", m_data, {32{8'hA0}});
    tick();
    pk_valid = 1'b0;
    send_pkt(2, 8'hA1, 1'b0, '0);
    settle_and_check("t1", 1, 0, 1'b0);

    // 2: dropped 4-beat packet then a forwarded one
    send_tuple({1'b1, 127'h2});
    first_wait = 0;
    send_pkt(4, 8'hB0, 1'b0, '0);
    chk("t2_drop_wait", 32'(first_wait), 32'd0);
    send_tuple(128'h3);
    send_pkt(2, 8'hB1, 1'b0, '0);
    settle_and_check("t2", 2, 1, 1'b0);

    // 3: tuple and first beat in the same cycle stall one cycle
    first_wait = 0;
    send_pkt(2, 8'hC0, 1'b1, 128'h4);
    chk("t3_stall_cycles", 32'(first_wait), 32'd1);
    settle_and_check("t3", 3, 1, 1'b0);

    // 4: five tuples back-to-back overflow a 4-deep FIFO
    for (int i = 0; i < 5; i++) send_tuple(128'h11 + 128'(i));
    @(negedge clk); chk("t4_ovf_now", ovf, 1'b1); tick();
    for (int i = 0; i < 4; i++) send_pkt(1 + (i % 2), 8'hD0 + 8'(i), 1'b0, '0);
    settle_and_check("t4", 7, 1, 1'b1);

    // 5: sink stall 1,0,0,1 across a 2-beat packet
    send_tuple(128'h5);
    fork
      send_pkt(2, 8'hE0, 1'b0, '0);
      begin
        m_ready = 1'b1; tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("t5_in_stall", tready, 1'b0);
        chk("t5_hold_vld", m_valid, 1'b1);
        chk("t5_hold_data", m_data, {32{8'hE0}});
        tick();
        m_ready = 1'b0; tick();
        m_ready = 1'b1;
      end
    join
    settle_and_check("t5", 8, 1, 1'b1);

    // 6: reset on beat 2 of 4 abandons the packet and clears everything
    send_tuple(128'h6);
    pk_valid = 1'b1; pk_data = {32{8'hF0}}; pk_keep = '1; pk_last = 1'b0;
    tick();
    pk_data = {32{8'hF1}}; rst = 1'b1;
    tick();
    rst = 1'b0; pk_valid = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", m_valid, 1'b0);
    chk("t6_tdata", m_data, 256'h0);
    chk("t6_tuser", m_user, 128'h0);
    chk("t6_fwd", fwd_cnt, 32'd0);
    chk("t6_drop", drop_cnt, 32'd0);
    chk("t6_ovf", ovf, 1'b0);
    tick();
    send_tuple(128'h7);
    send_pkt(2, 8'h70, 1'b0, '0);
    settle_and_check("t6_after", 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
